// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction memory loader.
// A byte moves on a rising edge where byte_valid and byte_ready are both high;
// the source holds byte_in/byte_valid until that edge, and byte_ready never depends on byte_valid.
interface imem_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Loads imem from a big-endian byte stream (16-bit word count header, then words)
// while holding the CPU in reset; releases the CPU once every declared word is written.
module imem_loader #(
  parameter int WORD_COUNT = 64,
  parameter int ADDR_LEN   = 32,
  parameter int INSTR_LEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  imem_loader_if.slave         stream,
  output logic                 imem_we,
  output logic [ADDR_LEN-1:0]  imem_addr,
  output logic [INSTR_LEN-1:0] imem_wdata,
  output logic                 cpu_rst,
  output logic                 load_done,
  output logic                 load_error,
  output logic [2:0]           state_dbg
);

  localparam int         IDX_W = $clog2(WORD_COUNT) + 1;
  localparam logic [15:0] MAX_N = 16'(WORD_COUNT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          count_q;
  logic [IDX_W-1:0]     word_idx_q;
  logic [1:0]           byte_cnt_q;
  logic [31:0]          shift_q;
  logic [ADDR_LEN-1:0]  addr_q;
  logic [INSTR_LEN-1:0] wdata_q;
  logic                 ready;
  logic                 xfer;
  logic [15:0]          hdr_n;
  logic                 last_word;

  assign ready     = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
  assign xfer      = ready && stream.byte_valid;
  assign hdr_n     = {count_q[15:8], stream.byte_in};
  assign last_word = (word_idx_q == IDX_W'(count_q - 16'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_HDR_HI;
      S_HDR_HI: if (xfer) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (xfer) begin
          if (hdr_n == 16'd0)     state_d = S_DONE;
          else if (hdr_n > MAX_N) state_d = S_ERROR;
          else                    state_d = S_DATA;
        end
      end
      S_DATA:   if (xfer && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE:  state_d = last_word ? S_DONE : S_DATA;
      S_DONE,
      S_ERROR:  if (start) state_d = S_HDR_HI;
      default:  state_d = S_IDLE;
    endcase
  end

  // Address and data are latched on the word's final byte so they stay stable outside WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        S_HDR_HI: if (xfer) count_q[15:8] <= stream.byte_in;
        S_HDR_LO: begin
          if (xfer) begin
            count_q[7:0] <= stream.byte_in;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            shift_q    <= {shift_q[23:0], stream.byte_in};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              addr_q  <= ADDR_LEN'({word_idx_q, 2'b00});
              wdata_q <= INSTR_LEN'({shift_q[23:0], stream.byte_in});
            end
          end
        end
        S_WRITE: word_idx_q <= word_idx_q + IDX_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    stream.byte_ready = ready;
    imem_we           = (state_q == S_WRITE);
    cpu_rst           = (state_q != S_DONE);
    load_done         = (state_q == S_DONE);
    load_error        = (state_q == S_ERROR);
    imem_addr         = addr_q;
    imem_wdata        = wdata_q;
    state_dbg         = state_q;
  end

endmodule
